// File: rtl/gpio_in_ctrl_if.sv
// Single-cycle request/acknowledge register bus between the core and gpio_in_ctrl.
`timescale 1ns/1ps
interface gpio_in_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o
    );
endinterface

// File: rtl/gpio_in_ctrl.sv
// Switch/key input peripheral: 2-FF synchroniser, per-bit debounce, sticky edge
// capture with selectable polarity, four-word register map and a level interrupt.
`timescale 1ns/1ps
module gpio_in_ctrl #(
    parameter int unsigned         NUM_IN          = 12,
    parameter int unsigned         DEBOUNCE_CYCLES = 250000,
    parameter logic [NUM_IN-1:0]   INIT_LEVEL      = NUM_IN'(12'hC00)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] in_i,
    gpio_in_ctrl_if.slave     bus,
    output logic              irq_o
);
    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_LEVEL  = 2'd0,
        REG_EDGE   = 2'd1,
        REG_IRQ_EN = 2'd2,
        REG_POL    = 2'd3
    } reg_sel_e;

    logic [NUM_IN-1:0] sync1, sync2, level;
    logic [CW-1:0]     cnt [NUM_IN];
    logic [NUM_IN-1:0] edge_q, irq_en, pol;
    logic [NUM_IN-1:0] fire, cap_set, edge_clr;
    logic [31:0]       rd_word;
    reg_sel_e          sel;
    logic              wr_en, rd_en;
    logic              unused_bits;

    assign unused_bits = ^{bus.addr_i[1:0], bus.wdata_i};

    always_comb begin
        fire    = '0;
        cap_set = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            fire[i]    = (sync2[i] != level[i]) && (cnt[i] == CNT_MAX);
            // sync2 is the level being adopted, so POL picks which direction counts.
            cap_set[i] = fire[i] && (pol[i] ? ~sync2[i] : sync2[i]);
        end
    end

    always_comb begin
        sel      = reg_sel_e'(bus.addr_i[3:2]);
        wr_en    = bus.req_i && bus.we_i;
        rd_en    = bus.req_i && !bus.we_i;
        edge_clr = (wr_en && sel == REG_EDGE) ? bus.wdata_i[NUM_IN-1:0] : '0;
        rd_word  = '0;
        case (sel)
            REG_LEVEL:  rd_word[NUM_IN-1:0] = level;
            REG_EDGE:   rd_word[NUM_IN-1:0] = edge_q;
            REG_IRQ_EN: rd_word[NUM_IN-1:0] = irq_en;
            REG_POL:    rd_word[NUM_IN-1:0] = pol;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= INIT_LEVEL;
            sync2 <= INIT_LEVEL;
            level <= INIT_LEVEL;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_i;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (fire[i]) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q      <= '0;
            irq_en      <= '0;
            pol         <= '0;
            irq_o       <= 1'b0;
            bus.ack_o   <= 1'b0;
            bus.rdata_o <= '0;
        end else begin
            // Set after clear so a capture coinciding with a W1C survives.
            edge_q      <= (edge_q & ~edge_clr) | cap_set;
            irq_o       <= |(edge_q & irq_en);
            bus.ack_o   <= bus.req_i;
            bus.rdata_o <= rd_en ? rd_word : '0;
            if (wr_en && sel == REG_IRQ_EN) begin
                irq_en <= bus.wdata_i[NUM_IN-1:0];
            end
            if (wr_en && sel == REG_POL) begin
                pol <= bus.wdata_i[NUM_IN-1:0];
            end
        end
    end
endmodule

// File: tb/tb_gpio_in_ctrl.sv
// Self-checking bench for gpio_in_ctrl: register-map vector table, hand-timed debounce
// and edge/irq sequences, then randomized traffic against a window-based reference model.
`timescale 1ns/1ps
module tb_gpio_in_ctrl;
    localparam int NI = 12;
    localparam int DB = 4;
    localparam logic [NI-1:0] INIT = 12'hC00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] in_v = INIT;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_in_ctrl_if bus ();

    gpio_in_ctrl #(
        .NUM_IN(NI),
        .DEBOUNCE_CYCLES(DB),
        .INIT_LEVEL(INIT)
    ) u_dut (
        .clk(clk),
        .rst(rst_n),
        .in_i(in_v),
        .bus(bus),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a two-deep delay line for the synchroniser and a window of the
    // last DB synchronised samples; a bit's level flips when the whole window disagrees.
    logic [NI-1:0] dly [$];
    logic [NI-1:0] hist [$];
    logic [NI-1:0] m_lvl, m_edge, m_ien, m_pol;
    logic          m_ack, m_was_read, m_irq;
    logic [31:0]   m_rdata;

    task automatic model_reset();
        dly.delete();
        hist.delete();
        for (int j = 0; j < 2; j++) dly.push_back(INIT);
        for (int j = 0; j < DB; j++) hist.push_back(INIT);
        m_lvl = INIT;
        m_edge = '0;
        m_ien = '0;
        m_pol = '0;
        m_ack = 1'b0;
        m_was_read = 1'b0;
        m_irq = 1'b0;
        m_rdata = '0;
    endtask

    task automatic model_step();
        logic [NI-1:0] s2, fire, set, clr;
        logic [1:0]    sel;
        logic          wr, all_diff;
        s2 = dly.pop_front();
        dly.push_back(in_v);
        hist.push_back(s2);
        hist.delete(0);
        fire = '0;
        set = '0;
        for (int b = 0; b < NI; b++) begin
            all_diff = 1'b1;
            foreach (hist[j]) if (hist[j][b] == m_lvl[b]) all_diff = 1'b0;
            fire[b] = all_diff;
            if (all_diff && ((~m_lvl[b]) == (~m_pol[b]))) set[b] = 1'b1;
        end
        sel = bus.addr_i[3:2];
        wr = bus.req_i && bus.we_i;
        m_ack = bus.req_i;
        m_was_read = bus.req_i && !bus.we_i;
        m_rdata = '0;
        if (m_was_read) begin
            case (sel)
                2'd0: m_rdata = {20'd0, m_lvl};
                2'd1: m_rdata = {20'd0, m_edge};
                2'd2: m_rdata = {20'd0, m_ien};
                default: m_rdata = {20'd0, m_pol};
            endcase
        end
        m_irq = |(m_edge & m_ien);
        clr = (wr && sel == 2'd1) ? bus.wdata_i[NI-1:0] : '0;
        m_edge = (m_edge & ~clr) | set;
        m_lvl = m_lvl ^ fire;
        if (wr && sel == 2'd2) m_ien = bus.wdata_i[NI-1:0];
        if (wr && sel == 2'd3) m_pol = bus.wdata_i[NI-1:0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_ack", {31'd0, bus.ack_o}, {31'd0, m_ack});
        if (!(m_ack && !m_was_read)) check("model_rdata", bus.rdata_o, m_rdata);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
        bus.req_i = 1'b0;
        bus.we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.req_i = 1'b1;
        bus.we_i = 1'b0;
        bus.addr_i = a;
        tick();
        d = bus.rdata_o;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.req_i = 1'b1;
        bus.we_i = 1'b1;
        bus.addr_i = a;
        bus.wdata_i = d;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        vt[0]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0C00};
        vt[1]  = '{1'b0, 4'h4, 32'h0,        32'h0};
        vt[2]  = '{1'b0, 4'h8, 32'h0,        32'h0};
        vt[3]  = '{1'b0, 4'hC, 32'h0,        32'h0};
        vt[4]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0};
        vt[5]  = '{1'b0, 4'hA, 32'h0,        32'h0000_0FFF};
        vt[6]  = '{1'b1, 4'hC, 32'h0000_05A5, 32'h0};
        vt[7]  = '{1'b0, 4'hF, 32'h0,        32'h0000_05A5};
        vt[8]  = '{1'b1, 4'h0, 32'h0000_0123, 32'h0};
        vt[9]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0C00};
        vt[10] = '{1'b1, 4'h8, 32'h0,        32'h0};
        vt[11] = '{1'b1, 4'hC, 32'h0,        32'h0};
        vt[12] = '{1'b0, 4'h8, 32'h0,        32'h0};
        vt[13] = '{1'b0, 4'hC, 32'h0,        32'h0};

        bus.req_i = 1'b0;
        bus.we_i = 1'b0;
        bus.addr_i = '0;
        bus.wdata_i = '0;
        #2;
        check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Register map, back-to-back accesses
        for (int i = 0; i < 14; i++) begin
            bus.req_i = 1'b1;
            bus.we_i = vt[i].we;
            bus.addr_i = vt[i].addr;
            bus.wdata_i = vt[i].wdata;
            tick();
            check("vec_ack", {31'd0, bus.ack_o}, 32'd1);
            if (!vt[i].we) check("vec_rdata", bus.rdata_o, vt[i].exp);
            check("vec_irq", {31'd0, irq}, 32'd0);
        end
        idle(1);
        check("idle_ack", {31'd0, bus.ack_o}, 32'd0);
        check("idle_rdata", bus.rdata_o, 32'd0);

        // Debounce latency: level changes at the 6th edge after the pad change
        in_v[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus_read(4'h0, d);
            check("latency_level", d, (k >= 7) ? 32'h0C01 : 32'h0C00);
        end
        bus_read(4'h4, d);
        check("latency_edge", d, 32'h1);
        check("latency_irq", {31'd0, irq}, 32'd0);

        // Short glitches never reach the debounced level
        for (int r = 0; r < 10; r++) begin
            in_v[1] = 1'b1;
            idle(3);
            in_v[1] = 1'b0;
            idle(3);
        end
        idle(8);
        bus_read(4'h0, d);
        check("glitch_level", d, 32'h0C01);
        bus_read(4'h4, d);
        check("glitch_edge", d, 32'h1);
        bus_write(4'h4, 32'hFFF);
        bus_read(4'h4, d);
        check("w1c_all", d, 32'h0);

        // Falling-edge capture on KEY0 raises irq; W1C drops it one cycle later
        bus_write(4'hC, 32'h400);
        bus_write(4'h8, 32'h400);
        in_v[10] = 1'b0;
        idle(8);
        check("key_irq", {31'd0, irq}, 32'd1);
        bus_read(4'h4, d);
        check("key_edge", d, 32'h400);
        bus_write(4'h4, 32'h400);
        check("key_irq_hold", {31'd0, irq}, 32'd1);
        idle(1);
        check("key_irq_drop", {31'd0, irq}, 32'd0);
        bus_read(4'h4, d);
        check("key_edge_clr", d, 32'h0);
        bus_read(4'h0, d);
        check("key_level", d, 32'h0801);

        // Capture and W1C on the same bit in the same cycle: set wins, irq stays high
        bus_write(4'h8, 32'h401);
        bus_write(4'hC, 32'h401);
        in_v[0] = 1'b0;
        idle(8);
        check("fall_irq", {31'd0, irq}, 32'd1);
        bus_write(4'hC, 32'h400);
        in_v[0] = 1'b1;
        idle(5);
        bus_write(4'h4, 32'h1);
        check("race_irq0", {31'd0, irq}, 32'd1);
        idle(1);
        check("race_irq1", {31'd0, irq}, 32'd1);
        bus_read(4'h4, d);
        check("race_edge", d, 32'h1);
        bus_write(4'h4, 32'hFFF);
        idle(2);
        check("race_irq_clr", {31'd0, irq}, 32'd0);

        // Reset during a partial debounce count
        in_v = 12'hC02;
        idle(4);
        rst_n = 1'b0;
        #2;
        check("rst2_ack", {31'd0, bus.ack_o}, 32'd0);
        check("rst2_rdata", bus.rdata_o, 32'd0);
        check("rst2_irq", {31'd0, irq}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(4'h4, d);
        check("rst2_edge", d, 32'h0);
        for (int k = 2; k <= 8; k++) begin
            bus_read(4'h0, d);
            check("rst2_level", d, (k >= 7) ? 32'h0C02 : 32'h0C00);
        end
        bus_read(4'h8, d);
        check("rst2_ien", d, 32'h0);
        bus_read(4'hC, d);
        check("rst2_pol", d, 32'h0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) begin
                int b;
                b = $urandom_range(NI - 1);
                in_v[b] = ~in_v[b];
            end
            if ($urandom_range(1) == 0) begin
                bus.req_i = 1'b1;
                bus.we_i = 1'($urandom_range(1));
                bus.addr_i = 4'($urandom_range(15));
                bus.wdata_i = $urandom;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
